// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-period math used by both RX and TX controllers,
// and the receiver state encoding.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  function automatic logic [31:0] one_cycle(input logic [31:0] clock_frequency,
                                            input logic [31:0] baud_rate);
    return clock_frequency / baud_rate;
  endfunction

  function automatic logic [31:0] half_cycle(input logic [31:0] clock_frequency,
                                             input logic [31:0] baud_rate);
    return one_cycle(clock_frequency, baud_rate) / 32'd2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reset value selectable
// so idle-high lines do not glitch out of reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver_controler.sv
// UART receive controller: recovers start/data/stop frames from rxd and writes
// good words into the RX FIFO, flagging framing errors and overruns as pulses.
module uart_receiver_controler
  import uart_pkg::*;
#(
  parameter logic [31:0] CLOCK_FREQUENCY = 32'd100_000_000,
  parameter logic [31:0] BAUD_RATE       = 32'd115200,
  parameter logic [31:0] WORD_WIDTH      = 32'd8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  input  logic                  full,
  output logic [WORD_WIDTH-1:0] dout,
  output logic                  we,
  output logic                  frame_error,
  output logic                  overrun
);

  localparam logic [31:0] ONE_CYCLE  = one_cycle(CLOCK_FREQUENCY, BAUD_RATE);
  localparam logic [31:0] HALF_CYCLE = half_cycle(CLOCK_FREQUENCY, BAUD_RATE);

  logic                  rxs;
  rx_state_t             state, state_n;
  logic [31:0]           clocks, clocks_n;
  logic [31:0]           bits, bits_n;
  logic [WORD_WIDTH-1:0] data, data_n;
  logic [WORD_WIDTH-1:0] dout_n;
  logic                  we_n, frame_error_n, overrun_n;

  sync_2ff #(.RST_VAL(1'b1)) u_rxd_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxs)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      clocks      <= '0;
      bits        <= '0;
      data        <= '0;
      dout        <= '0;
      we          <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_n;
      clocks      <= clocks_n;
      bits        <= bits_n;
      data        <= data_n;
      dout        <= dout_n;
      we          <= we_n;
      frame_error <= frame_error_n;
      overrun     <= overrun_n;
    end
  end

  always_comb begin
    state_n       = state;
    clocks_n      = clocks;
    bits_n        = bits;
    data_n        = data;
    dout_n        = dout;
    we_n          = 1'b0;
    frame_error_n = 1'b0;
    overrun_n     = 1'b0;
    case (state)
      IDLE: begin
        clocks_n = '0;
        bits_n   = '0;
        if (!rxs) state_n = START;
      end
      // Re-check the line at mid start bit so short glitches are ignored.
      START: begin
        if (clocks == HALF_CYCLE - 32'd1) begin
          clocks_n = '0;
          state_n  = rxs ? IDLE : DATA;
        end else begin
          clocks_n = clocks + 32'd1;
        end
      end
      DATA: begin
        if (clocks == ONE_CYCLE - 32'd1) begin
          data_n   = {rxs, data[WORD_WIDTH-1:1]};
          clocks_n = '0;
          bits_n   = bits + 32'd1;
          if (bits == WORD_WIDTH - 32'd1) state_n = STOP;
        end else begin
          clocks_n = clocks + 32'd1;
        end
      end
      STOP: begin
        if (clocks == ONE_CYCLE - 32'd1) begin
          clocks_n = '0;
          if (rxs) begin
            state_n = IDLE;
            if (full) begin
              overrun_n = 1'b1;
            end else begin
              dout_n = data;
              we_n   = 1'b1;
            end
          end else begin
            frame_error_n = 1'b1;
            state_n       = BREAK;
          end
        end else begin
          clocks_n = clocks + 32'd1;
        end
      end
      // Swallow a held-low line so a break reports only once.
      BREAK: begin
        clocks_n = '0;
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_receiver_controler.sv
// Directed bench for the UART receiver at 16 clocks per bit: table of frames
// plus hand sequences for glitch, framing/break and mid-frame reset.
module tb_uart_receiver_controler;
  import uart_pkg::*;

  localparam int BT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       full;
  logic [7:0] dout;
  logic       we, frame_error, overrun;

  uart_receiver_controler #(
    .CLOCK_FREQUENCY(32'd16),
    .BAUD_RATE      (32'd1),
    .WORD_WIDTH     (32'd8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rxd         (rxd),
    .full        (full),
    .dout        (dout),
    .we          (we),
    .frame_error (frame_error),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int we_cnt = 0, fe_cnt = 0, ov_cnt = 0;
  int we_cyc = 0, start_cyc = 0;
  logic [7:0] last_we_dout = 8'h00;
  int total = 0, bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (we) begin
        we_cnt++;
        we_cyc = cyc;
        last_we_dout = dout;
      end
      if (frame_error) fe_cnt++;
      if (overrun) ov_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    @(negedge clk);
    start_cyc = cyc;
    rxd = 1'b0;
    repeat (BT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (BT) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (BT - 1) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       full;
    int         gap;
    int         exp_we;
    int         exp_ov;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int w0, f0, o0;
    vecs[0] = '{8'hA5, 1'b0, 32, 1, 0, 8'hA5};
    vecs[1] = '{8'h00, 1'b0, 0,  1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b0, 32, 1, 0, 8'hFF};
    vecs[3] = '{8'h55, 1'b1, 32, 0, 1, 8'hFF};
    vecs[4] = '{8'h5A, 1'b0, 32, 1, 0, 8'h5A};

    rst = 1'b1; rxd = 1'b1; full = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_dout", 32'(dout), 32'h0);
    chk("reset_we", 32'(we), 32'h0);
    chk("reset_fe", 32'(frame_error), 32'h0);
    chk("reset_ov", 32'(overrun), 32'h0);
    rst = 1'b0;
    idle(20);

    for (int v = 0; v < 5; v++) begin
      w0 = we_cnt; f0 = fe_cnt; o0 = ov_cnt;
      full = vecs[v].full;
      send_frame(vecs[v].data, 1'b1);
      full = 1'b0;
      #1;
      chk($sformatf("v%0d_we", v), 32'(we_cnt - w0), 32'(vecs[v].exp_we));
      chk($sformatf("v%0d_ov", v), 32'(ov_cnt - o0), 32'(vecs[v].exp_ov));
      chk($sformatf("v%0d_fe", v), 32'(fe_cnt - f0), 32'h0);
      chk($sformatf("v%0d_dout", v), 32'(dout), 32'(vecs[v].exp_dout));
      if (vecs[v].exp_we != 0)
        chk($sformatf("v%0d_we_dout", v), 32'(last_we_dout), 32'(vecs[v].exp_dout));
      if (v == 0)
        chk("we_latency", 32'(we_cyc - start_cyc), 32'd155);
      if (vecs[v].gap > 0) idle(vecs[v].gap);
    end

    // glitch: short low pulse rejected at mid start bit
    w0 = we_cnt; f0 = fe_cnt;
    @(negedge clk);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    idle(30);
    chk("glitch_we", 32'(we_cnt - w0), 32'h0);
    chk("glitch_fe", 32'(fe_cnt - f0), 32'h0);
    chk("glitch_state", 32'(dut.state), 32'(IDLE));

    // framing error followed by a held-low break
    w0 = we_cnt; f0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    idle(48);
    chk("break_fe", 32'(fe_cnt - f0), 32'h1);
    chk("break_we", 32'(we_cnt - w0), 32'h0);
    chk("break_state", 32'(dut.state), 32'(IDLE));
    w0 = we_cnt;
    send_frame(8'h3C, 1'b1);
    #1;
    chk("after_break_we", 32'(we_cnt - w0), 32'h1);
    chk("after_break_dout", 32'(dout), 32'h3C);
    idle(32);

    // reset during data bit 3 of 0x81
    w0 = we_cnt; f0 = fe_cnt; o0 = ov_cnt;
    @(negedge clk);
    rxd = 1'b0;
    repeat (BT) @(negedge clk);
    rxd = 1'b1; repeat (BT) @(negedge clk);
    rxd = 1'b0; repeat (2 * BT + 8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rxd = 1'b1;
    #1;
    chk("midrst_dout", 32'(dout), 32'h0);
    chk("midrst_we", 32'(we), 32'h0);
    chk("midrst_state", 32'(dut.state), 32'(IDLE));
    idle(40);
    chk("midrst_no_we", 32'(we_cnt - w0), 32'h0);
    chk("midrst_no_err", 32'((fe_cnt - f0) + (ov_cnt - o0)), 32'h0);
    send_frame(8'h81, 1'b1);
    #1;
    chk("post_rst_we", 32'(we_cnt - w0), 32'h1);
    chk("post_rst_dout", 32'(dout), 32'h81);
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_receiver_controler.md
# uart_receiver_controler

Receive side of the UART link: samples the asynchronous serial line `rxd`, recovers 8N1-style frames (one start bit, `WORD_WIDTH` data bits LSB first, one stop bit), and pushes each good word into the RX FIFO with a one-cycle write strobe. It sits between the board RX pin and the RX FIFO. It is the counterpart of the transmitter controller, which pops the TX FIFO. Line-level errors are reported as single-cycle pulses for the status/CSR logic.

## Interface
- `CLOCK_FREQUENCY`, 32'd100_000_000, clk frequency in Hz
- `BAUD_RATE`, 32'd115200, line rate in bit/s
- `WORD_WIDTH`, 32'd8, data bits per frame

- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `rxd`  in  1  asynchronous serial input; idle level 1
- `full`  in  1  RX FIFO full
- `dout`  out  WORD_WIDTH  last received good word; valid while `we`=1 and held afterwards
- `we`  out  1  FIFO write strobe; one cycle per accepted word
- `frame_error`  out  1  one-cycle pulse; stop bit sampled as 0
- `overrun`  out  1  one-cycle pulse; good word dropped because `full`=1

## Operation
- Constants: ONE_CYCLE = CLOCK_FREQUENCY / BAUD_RATE (integer divide); HALF_CYCLE = ONE_CYCLE / 2.
- `rxd` passes through a 2-flop synchronizer. Both flops reset to 1. All decisions use the synchronized value `rxs`.
- `clocks` is a 32-bit bit-timer. `bits` is a 32-bit data-bit counter. `data` is a WORD_WIDTH shift register.
- State machine (reset → IDLE):
  - IDLE: `clocks`=0, `bits`=0. If `rxs`=0, go to START.
  - START: `clocks` increments. At `clocks`==HALF_CYCLE-1: if `rxs`=0, go to DATA with `clocks`←0; if `rxs`=1 (glitch), go to IDLE.
  - DATA: at `clocks`==ONE_CYCLE-1, `data`←{`rxs`, `data`[W-1:1]}, `clocks`←0, `bits`++. When the shift for bit WORD_WIDTH-1 occurs, go to STOP.
  - STOP: at `clocks`==ONE_CYCLE-1, sample `rxs`:
    - 1 and `full`=0: `dout`←`data`, `we`←1, go to IDLE.
    - 1 and `full`=1: `overrun`←1, `dout` unchanged, go to IDLE.
    - 0: `frame_error`←1, go to BREAK.
  - BREAK: wait until `rxs`=1, then go to IDLE. A held-low line (break) yields exactly one `frame_error` and no phantom frames.
- `full` is sampled only on the stop-sample cycle.
- The FIFO is never written when `full`=1.

## Timing
- Reset values: `we`=0, `frame_error`=0, `overrun`=0, `dout`=0, synchronizer=1, state IDLE.
- `rst` mid-frame aborts the frame immediately: no strobe, no error pulse.
- All outputs are registered; no combinational path from `rxd` or `full`.
- Start detection: 2 cycles synchronizer latency, plus 1 cycle (IDLE→START).
- Sample points sit at bit centres, ±1 cycle quantization.
- Strobe timing: `we`, `overrun` and `frame_error` are asserted in the cycle after the stop-bit centre sample, for exactly 1 cycle.
- Back-to-back frames: the receiver returns to IDLE half a bit into the stop bit, so a start edge directly after a full stop bit is caught. Minimum spacing is 1 stop bit.
- Counters never wrap: `clocks` is bounded by ONE_CYCLE-1 and `bits` by WORD_WIDTH.

## Structure
- Package `uart_pkg` holds:
  - the ONE_CYCLE/HALF_CYCLE computation as a function of CLOCK_FREQUENCY and BAUD_RATE, shared with the transmitter;
  - the `rx_state_t` enum (IDLE, START, DATA, STOP, BREAK; 3-bit).
- Sub-module `sync_2ff` (1-bit, reset value parameter) implements the synchronizer and is reusable for other async inputs.
- Everything else is in one module.

## Test plan
All scenarios use CLOCK_FREQUENCY=16, BAUD_RATE=1, so ONE_CYCLE=16 and HALF_CYCLE=8.
- Good frame: send 0xA5 (start, 1,0,1,0,0,1,0,1, stop), `full`=0 → exactly one `we` pulse with `dout`=0xA5; no error pulses.
- Back-to-back: send 0x00 then 0xFF with 1 stop bit between → two `we` pulses, `dout`=0x00 then 0xFF.
- Glitch: drive `rxd` low for 4 cycles, then high → state returns to IDLE; no `we`, no `frame_error`.
- Framing and break: send 0x3C with stop=0, then hold low for 40 cycles, then release → one `frame_error` pulse, no `we`. A following 0x3C frame is received correctly.
- Overrun: `full`=1 during the stop sample of 0x55 → one `overrun` pulse, no `we`, `dout` keeps its previous value.
- Reset mid-frame: assert `rst` during data bit 3 → outputs at reset values, no strobe. The next full 0x81 frame is received normally.
